// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// One shift-add (multiply) or restoring subtract-shift (divide) step is done per cycle
// on operand magnitudes. The sign is fixed up when the result is registered.
// Division by zero, signed overflow and illegal encodings skip the iteration
// and go straight to DONE.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             status,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CW-1:0]        r_count;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_opnd;
  logic [2:0]           r_funct3;
  logic                 r_negq;
  logic                 r_negr;
  logic [WIDTH-1:0]     r_result;
  logic                 r_zero;
  logic                 r_status;

  logic                 w_illegal;
  logic                 w_isDiv;
  logic                 w_op1Signed;
  logic                 w_op2Signed;
  logic                 w_op1Neg;
  logic                 w_op2Neg;
  logic [WIDTH-1:0]     w_op1Mag;
  logic [WIDTH-1:0]     w_op2Mag;
  logic                 w_divZero;
  logic                 w_overflow;
  logic                 w_shortcut;
  logic [WIDTH-1:0]     w_shortResult;
  logic                 w_lastStep;
  logic [WIDTH:0]       w_mulSum;
  logic [WIDTH:0]       w_divShift;
  logic [WIDTH:0]       w_divDiff;
  logic [2*WIDTH-1:0]   w_stepAcc;
  logic [2*WIDTH-1:0]   w_prodFix;
  logic [WIDTH-1:0]     w_quot;
  logic [WIDTH-1:0]     w_rem;
  logic [WIDTH-1:0]     w_calcResult;

  // Request decode: legality, signedness and magnitudes of the incoming operands.
  // MUL/MULH/MULHSU/DIV/REM treat op1 as signed. Only MULHSU differs for op2.
  assign w_illegal   = (opcode != 7'b0110011) || (funct7 != 7'b0000001);
  assign w_isDiv     = funct3[2];
  assign w_op1Signed = (funct3 != 3'd3) && (funct3 != 3'd5) && (funct3 != 3'd7);
  assign w_op2Signed = w_op1Signed && (funct3 != 3'd2);
  assign w_op1Neg    = w_op1Signed & op1[WIDTH-1];
  assign w_op2Neg    = w_op2Signed & op2[WIDTH-1];
  assign w_op1Mag    = w_op1Neg ? -op1 : op1;
  assign w_op2Mag    = w_op2Neg ? -op2 : op2;
  assign w_divZero   = w_isDiv & (op2 == '0);
  assign w_overflow  = w_isDiv & ~funct3[0] & (op1 == {1'b1, {(WIDTH-1){1'b0}}}) & (&op2);
  assign w_shortcut  = w_illegal | w_divZero | w_overflow;
  assign w_lastStep  = (r_count == CW'(WIDTH-1));

  // Final value for the requests that never enter CALC (funct3[1] selects REM/REMU).
  always_comb begin
    w_shortResult = '0;
    if (w_illegal) begin
      w_shortResult = '0;
    end else if (w_divZero) begin
      w_shortResult = funct3[1] ? op1 : '1;
    end else if (w_overflow) begin
      w_shortResult = funct3[1] ? '0 : op1;
    end
  end

  // One iteration of the datapath. The upper half of r_acc is the partial product or remainder.
  // The lower half is the multiplier being shifted out, or the dividend being shifted into quotient bits.
  always_comb begin
    w_mulSum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_divShift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_divDiff  = w_divShift - {1'b0, r_opnd};
    if (r_funct3[2]) begin
      if (!w_divDiff[WIDTH]) begin
        w_stepAcc = {w_divDiff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      end else begin
        w_stepAcc = {w_divShift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_stepAcc = {w_mulSum, r_acc[WIDTH-1:1]};
    end
  end

  // Sign fixup and result selection applied on the final iteration.
  always_comb begin
    w_prodFix = r_negq ? -w_stepAcc : w_stepAcc;
    w_quot    = r_negq ? -w_stepAcc[WIDTH-1:0] : w_stepAcc[WIDTH-1:0];
    w_rem     = r_negr ? -w_stepAcc[2*WIDTH-1:WIDTH] : w_stepAcc[2*WIDTH-1:WIDTH];
    case (r_funct3)
      3'd0:          w_calcResult = w_prodFix[WIDTH-1:0];
      3'd1, 3'd2,
      3'd3:          w_calcResult = w_prodFix[2*WIDTH-1:WIDTH];
      3'd4, 3'd5:    w_calcResult = w_quot;
      default:       w_calcResult = w_rem;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic. Flush overrides accept and retire.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req_valid) w_next = w_shortcut ? S_DONE : S_CALC;
      S_CALC: if (w_lastStep) w_next = S_DONE;
      S_DONE: if (resp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  // Handshake outputs decoded from state; the result fields come from registers.
  always_comb begin
    req_ready  = (r_state == S_IDLE);
    resp_valid = (r_state == S_DONE);
    busy       = (r_state != S_IDLE);
    result     = r_result;
    zero       = r_zero;
    status     = r_status;
  end

  // Datapath registers: latch operands on accept, iterate in CALC, and hold the result otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_funct3 <= '0;
      r_negq   <= 1'b0;
      r_negr   <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_status <= 1'b0;
    end else if (!flush) begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_funct3 <= funct3;
            r_negq   <= w_op1Neg ^ w_op2Neg;
            r_negr   <= w_op1Neg;
            r_count  <= '0;
            if (w_shortcut) begin
              r_result <= w_shortResult;
              r_zero   <= (w_shortResult == '0);
              r_status <= w_illegal;
            end else if (w_isDiv) begin
              r_acc  <= {{WIDTH{1'b0}}, w_op1Mag};
              r_opnd <= w_op2Mag;
            end else begin
              r_acc  <= {{WIDTH{1'b0}}, w_op2Mag};
              r_opnd <= w_op1Mag;
            end
          end
        end
        S_CALC: begin
          r_acc <= w_stepAcc;
          if (w_lastStep) begin
            r_result <= w_calcResult;
            r_zero   <= (w_calcResult == '0);
            r_status <= 1'b0;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: bench for muldiv_unit. It checks the unit against directed vectors
// through a scoreboard queue and a monitor process that checks each response as it retires.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] result;
  logic        zero;
  logic        status;
  logic        busy;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        st;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   acceptCyc = 0;
  logic prevValid = 1'b0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .op1        (op1),
    .op2        (op2),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7     (funct7),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .result     (result),
    .zero       (zero),
    .status     (status),
    .busy       (busy)
  );

  // 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running edge counter, used to measure response latency from the accept edge.
  always @(posedge clk) cyc++;

  // Compares one observed value with its expected value and updates the counters.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: on the rise of resp_valid it checks latency. On each retiring handshake it pops the
  // oldest expectation and compares result/zero/status. A response that appears with nothing
  // outstanding counts as a failure.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prevValid = 1'b0;
    end else begin
      if (resp_valid && !prevValid) begin
        if (sbq.size() == 0) checkOutput("unexpected_resp", 32'd1, 32'd0);
        else checkOutput("latency", 32'(cyc - acceptCyc), 32'(sbq[0].lat));
      end
      if (resp_valid && resp_ready && sbq.size() > 0) begin
        e = sbq.pop_front();
        checkOutput("result", result, e.res);
        checkOutput("zero", {31'd0, zero}, {31'd0, e.z});
        checkOutput("status", {31'd0, status}, {31'd0, e.st});
      end
      prevValid = resp_valid;
    end
  end

  // Issues one request when the unit is ready and optionally records its expected response.
  // After the accept edge the operand inputs are scrambled, so a unit that fails to latch them shows up.
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                               input logic [6:0] opc, input logic [6:0] f7, input bit pushExp,
                               input logic [31:0] expRes, input logic expSt, input int expLat);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checkOutput("req_ready_timeout", 32'd0, 32'd1);
      return;
    end
    if (pushExp) begin
      e.res = expRes;
      e.z   = (expRes == 32'd0);
      e.st  = expSt;
      e.lat = expLat;
      sbq.push_back(e);
    end
    req_valid = 1'b1;
    op1 = a;
    op2 = b;
    funct3 = f3;
    opcode = opc;
    funct7 = f7;
    @(posedge clk);
    #1;
    acceptCyc = cyc;
    req_valid = 1'b0;
    op1 = $urandom;
    op2 = $urandom;
    funct3 = 3'($urandom);
    opcode = 7'b0110011;
    funct7 = 7'b0000001;
  endtask

  // Waits, for a bounded time, until every recorded expectation has been consumed by the monitor.
  task automatic waitDrain();
    int n = 0;
    while (sbq.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() > 0) begin
      checkOutput("drain_timeout", 32'(sbq.size()), 32'd0);
      sbq.delete();
    end
    @(negedge clk);
  endtask

  localparam logic [6:0] OPC = 7'b0110011;
  localparam logic [6:0] F7  = 7'b0000001;

  // Main sequence: reset, directed arithmetic vectors, shortcuts, back-pressure, flush, and mid-operation reset.
  initial begin
    int n;
    int seen;
    rst_n = 1'b0;
    flush = 1'b0;
    req_valid = 1'b0;
    resp_ready = 1'b1;
    op1 = '0;
    op2 = '0;
    opcode = OPC;
    funct3 = '0;
    funct7 = F7;
    #12;
    checkOutput("rst_result", result, 32'd0);
    checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_zero_status", {30'd0, zero, status}, 32'd0);
    rst_n = 1'b1;

    applyStimulus(3'd0, 32'd5, 32'd3, OPC, F7, 1, 32'd15, 1'b0, 32);
    applyStimulus(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, OPC, F7, 1, 32'h00000000, 1'b0, 32);
    applyStimulus(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, OPC, F7, 1, 32'hFFFFFFFE, 1'b0, 32);
    applyStimulus(3'd2, 32'hFFFFFFFF, 32'd2, OPC, F7, 1, 32'hFFFFFFFF, 1'b0, 32);
    applyStimulus(3'd0, 32'hFFFFFFFD, 32'd4, OPC, F7, 1, 32'hFFFFFFF4, 1'b0, 32);
    applyStimulus(3'd4, 32'hFFFFFFF9, 32'd2, OPC, F7, 1, 32'hFFFFFFFD, 1'b0, 32);
    applyStimulus(3'd6, 32'hFFFFFFF9, 32'd2, OPC, F7, 1, 32'hFFFFFFFF, 1'b0, 32);
    applyStimulus(3'd4, 32'd7, 32'hFFFFFFFE, OPC, F7, 1, 32'hFFFFFFFD, 1'b0, 32);
    applyStimulus(3'd6, 32'd7, 32'hFFFFFFFE, OPC, F7, 1, 32'd1, 1'b0, 32);
    applyStimulus(3'd5, 32'd100, 32'd7, OPC, F7, 1, 32'd14, 1'b0, 32);
    applyStimulus(3'd7, 32'd100, 32'd7, OPC, F7, 1, 32'd2, 1'b0, 32);
    applyStimulus(3'd4, 32'h80000000, 32'hFFFFFFFF, OPC, F7, 1, 32'h80000000, 1'b0, 0);
    applyStimulus(3'd6, 32'h80000000, 32'hFFFFFFFF, OPC, F7, 1, 32'd0, 1'b0, 0);
    applyStimulus(3'd0, 32'd5, 32'd3, 7'd0, F7, 1, 32'd0, 1'b1, 0);
    applyStimulus(3'd4, 32'd9, 32'd3, OPC, 7'd0, 1, 32'd0, 1'b1, 0);
    waitDrain();

    // Back-pressure: the result must stay put and the unit must refuse new work until it retires.
    resp_ready = 1'b0;
    applyStimulus(3'd0, 32'd5, 32'd3, OPC, F7, 1, 32'd15, 1'b0, 32);
    n = 0;
    while (!resp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!resp_valid) checkOutput("hold_valid_timeout", 32'd0, 32'd1);
    repeat (5) begin
      @(negedge clk);
      checkOutput("hold_result", result, 32'd15);
      checkOutput("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    @(posedge clk);
    #1 checkOutput("ready_after_retire", {31'd0, req_ready}, 32'd1);
    waitDrain();

    applyStimulus(3'd5, 32'd7, 32'd0, OPC, F7, 1, 32'hFFFFFFFF, 1'b0, 0);
    applyStimulus(3'd7, 32'd7, 32'd0, OPC, F7, 1, 32'd7, 1'b0, 0);
    waitDrain();

    // Flush during CALC: back to idle at once, no response, last result retained.
    applyStimulus(3'd0, 32'd123, 32'd456, OPC, F7, 0, 32'd0, 1'b0, 0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    checkOutput("flush_busy", {31'd0, busy}, 32'd0);
    checkOutput("flush_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("flush_result_kept", result, 32'd7);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    checkOutput("flush_no_resp", 32'(seen), 32'd0);

    // Asynchronous reset in the middle of CALC: outputs return to reset values without a clock edge.
    applyStimulus(3'd0, 32'd5, 32'd3, OPC, F7, 0, 32'd0, 1'b0, 0);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("arst_result", result, 32'd0);
    checkOutput("arst_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("arst_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("arst_busy", {31'd0, busy}, 32'd0);
    checkOutput("arst_zero_status", {30'd0, zero, status}, 32'd0);
    #2 rst_n = 1'b1;

    applyStimulus(3'd0, 32'd6, 32'd7, OPC, F7, 1, 32'd42, 1'b0, 32);
    waitDrain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
